dbg_cmd_parser: RTL and testbench



---
 rtl/dbg_pkg.sv | 28 ++
 rtl/dbg_regbank.sv | 53 +++++
 rtl/dbg_cmd_parser.sv | 162 ++++++++++++++++
 tb/tb_dbg_cmd_parser.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/dbg_pkg.sv
// Shared constants and types for the serial debug command parser.
package dbg_pkg;

    // Command opcodes (first byte of a frame)
    localparam logic [7:0] OP_INC = 8'h00;
    localparam logic [7:0] OP_RD  = 8'h01;
    localparam logic [7:0] OP_WR  = 8'h02;

    // Response bytes
    localparam logic [7:0] RSP_ACK = 8'hA5;
    localparam logic [7:0] RSP_ERR = 8'hEE;

    // Register bank addresses
    localparam logic [1:0] ADDR_CNT_LO  = 2'd0;
    localparam logic [1:0] ADDR_CNT_HI  = 2'd1;
    localparam logic [1:0] ADDR_SCRATCH = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    // Parser states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_GET_DATA,
        ST_RESP,
        ST_GUARD
    } state_e;

endpackage

// File: rtl/dbg_regbank.sv
// Debug register bank: 16-bit command counter, scratch byte, sticky overrun.
module dbg_regbank
    import dbg_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       inc_i,
    input  logic       we_i,
    input  logic [1:0] waddr_i,
    input  logic [7:0] wdata_i,
    input  logic       set_ovr_i,
    input  logic [1:0] raddr_i,
    output logic [7:0] rdata_o,
    output logic [7:0] scratch_o
);

    logic [15:0] count_q;
    logic [7:0]  scratch_q;
    logic        overrun_q;

    // Storage: counter wraps naturally at 16 bits; a status write clears overrun,
    // but a simultaneous overrun event takes priority so no drop is ever lost.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q   <= '0;
            scratch_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values, independent of statement order.
            if (inc_i)
                count_q <= count_q + 16'd1;
            if (we_i && waddr_i == ADDR_SCRATCH)
                scratch_q <= wdata_i;
            if (set_ovr_i)
                overrun_q <= 1'b1;
            else if (we_i && waddr_i == ADDR_STATUS)
                overrun_q <= 1'b0;
        end
    end

    // Read mux; reads have no side effects.
    always_comb begin
        unique case (raddr_i)
            ADDR_CNT_LO:  rdata_o = count_q[7:0];
            ADDR_CNT_HI:  rdata_o = count_q[15:8];
            ADDR_SCRATCH: rdata_o = scratch_q;
            default:      rdata_o = {7'b0, overrun_q};
        endcase
    end

    assign scratch_o = scratch_q;

endmodule

// File: rtl/dbg_cmd_parser.sv
// Framed read/write command parser between uart_rx and uart_tx, with
// inter-byte timeout and exactly one response byte per complete command.
module dbg_cmd_parser
    import dbg_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1200000,
    parameter int unsigned TW      = 21
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rcv,
    input  logic [7:0] data,
    input  logic       tx_ready,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic [3:0] leds,
    output logic       act
);

    state_e        state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [1:0]    guard_q, guard_d;
    logic          is_wr_q, is_wr_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    tx_data_q, tx_data_d;

    logic          rb_inc, rb_we, rb_set_ovr;
    logic [7:0]    rb_rdata, rb_scratch;
    logic          tmo_hit;

    dbg_regbank u_regbank (
        .clk       (clk),
        .rstn      (rstn),
        .inc_i     (rb_inc),
        .we_i      (rb_we),
        .waddr_i   (addr_q[1:0]),
        .wdata_i   (data),
        .set_ovr_i (rb_set_ovr),
        .raddr_i   (data[1:0]),
        .rdata_o   (rb_rdata),
        .scratch_o (rb_scratch)
    );

    assign tmo_hit = (tmo_q == TW'(TIMEOUT));

    // State register and parser datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            tmo_q     <= '0;
            guard_q   <= '0;
            is_wr_q   <= 1'b0;
            addr_q    <= '0;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            guard_q   <= guard_d;
            is_wr_q   <= is_wr_d;
            addr_q    <= addr_d;
            tx_data_q <= tx_data_d;
        end
    end

    // Next-state logic: frame decoding, timeout, guard wait and bank control.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value unassigned and infers a latch.
        state_d    = state_q;
        tmo_d      = '0;
        guard_d    = guard_q;
        is_wr_d    = is_wr_q;
        addr_d     = addr_q;
        tx_data_d  = tx_data_q;
        rb_inc     = 1'b0;
        rb_we      = 1'b0;
        rb_set_ovr = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (rcv) begin
                    case (data)
                        OP_INC: begin
                            rb_inc    = 1'b1;
                            tx_data_d = RSP_ACK;
                            state_d   = ST_RESP;
                        end
                        OP_RD: begin
                            is_wr_d = 1'b0;
                            state_d = ST_GET_ADDR;
                        end
                        OP_WR: begin
                            is_wr_d = 1'b1;
                            state_d = ST_GET_ADDR;
                        end
                        default: begin
                            tx_data_d = RSP_ERR;
                            state_d   = ST_RESP;
                        end
                    endcase
                end
            end
            ST_GET_ADDR: begin
                // A byte in the timeout cycle still counts: rcv has priority.
                if (rcv) begin
                    addr_d = data;
                    if (is_wr_q) begin
                        state_d = ST_GET_DATA;
                    end else begin
                        tx_data_d = (data[7:2] != '0) ? RSP_ERR : rb_rdata;
                        state_d   = ST_RESP;
                    end
                end else if (tmo_hit) begin
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_GET_DATA: begin
                if (rcv) begin
                    // Only scratch and status accept writes; the counter is read-only.
                    if (addr_q[7:2] == '0 && addr_q[1]) begin
                        rb_we     = 1'b1;
                        tx_data_d = RSP_ACK;
                    end else begin
                        tx_data_d = RSP_ERR;
                    end
                    state_d = ST_RESP;
                end else if (tmo_hit) begin
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_RESP: begin
                rb_set_ovr = rcv;
                if (tx_ready) begin
                    guard_d = '0;
                    state_d = ST_GUARD;
                end
            end
            ST_GUARD: begin
                // Two blind cycles give uart_tx time to drop ready after the start pulse.
                rb_set_ovr = rcv;
                if (guard_q != 2'd2)
                    guard_d = guard_q + 2'd1;
                else if (tx_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: start pulse on the first ready cycle in RESP, activity flag.
    always_comb begin
        tx_start = (state_q == ST_RESP) && tx_ready;
        act      = (state_q != ST_IDLE);
    end

    assign tx_data = tx_data_q;
    assign leds    = rb_scratch[3:0];

endmodule

// File: tb/tb_dbg_cmd_parser.sv
// Directed self-checking bench for dbg_cmd_parser (short TIMEOUT for sim speed).
module tb_dbg_cmd_parser;

    localparam int unsigned TMO = 40;

    logic       clk = 1'b0;
    logic       rstn;
    logic       rcv;
    logic [7:0] data;
    logic       tx_ready;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [3:0] leds;
    logic       act;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] resp_q[$];

    dbg_cmd_parser #(.TIMEOUT(TMO), .TW(8)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rcv      (rcv),
        .data     (data),
        .tx_ready (tx_ready),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .leds     (leds),
        .act      (act)
    );

    always #5 clk = ~clk;

    // Capture every response byte at the moment tx_start is seen.
    always @(negedge clk) if (rstn && tx_start === 1'b1) resp_q.push_back(tx_data);

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        data = b;
        rcv  = 1'b1;
        @(negedge clk);
        rcv  = 1'b0;
    endtask

    // Returns the next response byte, or X if none arrives in time; then waits for IDLE.
    task automatic get_resp(output logic [7:0] v);
        v = 'x;
        for (int i = 0; i < 100 && resp_q.size() == 0; i++) @(negedge clk);
        if (resp_q.size() > 0) v = resp_q.pop_front();
        for (int i = 0; i < 100 && act !== 1'b0; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        n_tests++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL rst_tx_start: got %b want 0", tx_start); end
        n_tests++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
        n_tests++; if (leds !== 4'h0)     begin n_fail++; $display("FAIL rst_leds: got %h want 0", leds); end
        n_tests++; if (act !== 1'b0)      begin n_fail++; $display("FAIL rst_act: got %b want 0", act); end
    endtask

    task automatic test_inc_read();
        logic [7:0] r;
        for (int i = 0; i < 3; i++) begin
            send_byte(8'h00); get_resp(r);
            n_tests++; if (r !== 8'hA5) begin n_fail++; $display("FAIL inc%0d: got %h want a5", i, r); end
        end
        send_byte(8'h01); send_byte(8'h00); get_resp(r);
        n_tests++; if (r !== 8'h03) begin n_fail++; $display("FAIL rd_cnt_lo: got %h want 03", r); end
        n_tests++; if (leds !== 4'h0) begin n_fail++; $display("FAIL inc_leds: got %h want 0", leds); end
    endtask

    task automatic test_write_read();
        logic [7:0] r;
        send_byte(8'h02); send_byte(8'h02); send_byte(8'h5C); get_resp(r);
        n_tests++; if (r !== 8'hA5) begin n_fail++; $display("FAIL wr_scratch: got %h want a5", r); end
        n_tests++; if (leds !== 4'hC) begin n_fail++; $display("FAIL wr_leds: got %h want c", leds); end
        send_byte(8'h01); send_byte(8'h02); get_resp(r);
        n_tests++; if (r !== 8'h5C) begin n_fail++; $display("FAIL rd_scratch: got %h want 5c", r); end
    endtask

    task automatic test_errors();
        logic [7:0] r;
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h11); get_resp(r);
        n_tests++; if (r !== 8'hEE) begin n_fail++; $display("FAIL err_wr_cnt: got %h want ee", r); end
        send_byte(8'h07); get_resp(r);
        n_tests++; if (r !== 8'hEE) begin n_fail++; $display("FAIL err_opcode: got %h want ee", r); end
        send_byte(8'h01); send_byte(8'h09); get_resp(r);
        n_tests++; if (r !== 8'hEE) begin n_fail++; $display("FAIL err_addr: got %h want ee", r); end
        send_byte(8'h02); send_byte(8'h06); send_byte(8'h77); get_resp(r);
        n_tests++; if (r !== 8'hEE) begin n_fail++; $display("FAIL err_wr_addr: got %h want ee", r); end
        send_byte(8'h01); send_byte(8'h00); get_resp(r);
        n_tests++; if (r !== 8'h03) begin n_fail++; $display("FAIL err_cnt_kept: got %h want 03", r); end
        send_byte(8'h01); send_byte(8'h02); get_resp(r);
        n_tests++; if (r !== 8'h5C) begin n_fail++; $display("FAIL err_scratch_kept: got %h want 5c", r); end
    endtask

    task automatic test_timeout();
        logic [7:0] r;
        send_byte(8'h01);
        n_tests++; if (act !== 1'b1) begin n_fail++; $display("FAIL tmo_act_busy: got %b want 1", act); end
        repeat (TMO + 5) @(negedge clk);
        n_tests++; if (act !== 1'b0) begin n_fail++; $display("FAIL tmo_act_idle: got %b want 0", act); end
        n_tests++; if (resp_q.size() != 0) begin n_fail++; $display("FAIL tmo_no_resp: got %0d responses want 0", resp_q.size()); end
        send_byte(8'h01); send_byte(8'h03); get_resp(r);
        n_tests++; if (r !== 8'h00) begin n_fail++; $display("FAIL tmo_status: got %h want 00", r); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] r;
        tx_ready = 1'b0;
        send_byte(8'h00);
        repeat (6) @(negedge clk);
        n_tests++; if (resp_q.size() != 0) begin n_fail++; $display("FAIL bp_no_start: got %0d responses want 0", resp_q.size()); end
        send_byte(8'h55);
        repeat (4) @(negedge clk);
        n_tests++; if (resp_q.size() != 0 || act !== 1'b1) begin n_fail++; $display("FAIL bp_held: got %0d responses act %b want 0 / 1", resp_q.size(), act); end
        tx_ready = 1'b1;
        get_resp(r);
        n_tests++; if (r !== 8'hA5) begin n_fail++; $display("FAIL bp_resp: got %h want a5", r); end
        n_tests++; if (resp_q.size() != 0) begin n_fail++; $display("FAIL bp_single: got %0d extra responses want 0", resp_q.size()); end
        send_byte(8'h01); send_byte(8'h03); get_resp(r);
        n_tests++; if (r !== 8'h01) begin n_fail++; $display("FAIL ovr_set: got %h want 01", r); end
        send_byte(8'h02); send_byte(8'h03); send_byte(8'h00); get_resp(r);
        n_tests++; if (r !== 8'hA5) begin n_fail++; $display("FAIL ovr_clr_wr: got %h want a5", r); end
        send_byte(8'h01); send_byte(8'h03); get_resp(r);
        n_tests++; if (r !== 8'h00) begin n_fail++; $display("FAIL ovr_cleared: got %h want 00", r); end
        send_byte(8'h01); send_byte(8'h00); get_resp(r);
        n_tests++; if (r !== 8'h04) begin n_fail++; $display("FAIL bp_cnt: got %h want 04", r); end
    endtask

    task automatic test_wrap();
        logic [7:0] r;
        @(negedge clk);
        force dut.u_regbank.count_q = 16'hFFFF;
        @(negedge clk);
        release dut.u_regbank.count_q;
        send_byte(8'h01); send_byte(8'h01); get_resp(r);
        n_tests++; if (r !== 8'hFF) begin n_fail++; $display("FAIL wrap_pre_hi: got %h want ff", r); end
        send_byte(8'h00); get_resp(r);
        n_tests++; if (r !== 8'hA5) begin n_fail++; $display("FAIL wrap_inc: got %h want a5", r); end
        send_byte(8'h01); send_byte(8'h00); get_resp(r);
        n_tests++; if (r !== 8'h00) begin n_fail++; $display("FAIL wrap_lo: got %h want 00", r); end
        send_byte(8'h01); send_byte(8'h01); get_resp(r);
        n_tests++; if (r !== 8'h00) begin n_fail++; $display("FAIL wrap_hi: got %h want 00", r); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] r;
        send_byte(8'h02); send_byte(8'h02);
        rstn = 1'b0;
        #1;
        n_tests++; if (tx_start !== 1'b0 || tx_data !== 8'h00) begin n_fail++; $display("FAIL mid_rst_tx: got %b/%h want 0/00", tx_start, tx_data); end
        n_tests++; if (leds !== 4'h0 || act !== 1'b0) begin n_fail++; $display("FAIL mid_rst_leds_act: got %h/%b want 0/0", leds, act); end
        @(negedge clk);
        rstn = 1'b1;
        send_byte(8'h02); send_byte(8'h02); send_byte(8'h33); get_resp(r);
        n_tests++; if (r !== 8'hA5 || leds !== 4'h3) begin n_fail++; $display("FAIL post_rst_wr: got %h/%h want a5/3", r, leds); end
        send_byte(8'h01); send_byte(8'h02); get_resp(r);
        n_tests++; if (r !== 8'h33) begin n_fail++; $display("FAIL post_rst_rd: got %h want 33", r); end
        n_tests++; if (resp_q.size() != 0) begin n_fail++; $display("FAIL post_rst_extra: got %0d extra responses want 0", resp_q.size()); end
    endtask

    initial begin
        rstn     = 1'b0;
        rcv      = 1'b0;
        data     = 8'h00;
        tx_ready = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        rstn = 1'b1;
        test_inc_read();
        test_write_read();
        test_errors();
        test_timeout();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
